// File: rtl/mdio_phy_init.sv
// PHY bring-up sequencer: holds the PHY in reset, waits for it to settle, then
// issues a small table of clause-22 MDIO register writes and reports completion.
// state      | meaning
// RESET_HOLD | phy_resetn low while the timer runs
// SETTLE     | phy_resetn high, waiting before the first frame
// LOAD       | build the frame for table entry idx
// SHIFT      | clock the frame out, one bit per MDC period
// GAP        | MDC idle between frames
// DONE       | sequence complete, waiting for restart
module mdio_phy_init #(
  parameter int unsigned HALF_PERIOD   = 32,
  parameter int unsigned RESET_CYCLES  = 1250000,
  parameter int unsigned SETTLE_CYCLES = 2500000,
  parameter logic [4:0]  PHY_ADDR      = 5'h00,
  parameter int unsigned NUM_WRITES    = 2,
  parameter logic [4:0]  REG0          = 5'h00,
  parameter logic [15:0] DATA0         = 16'h1140,
  parameter logic [4:0]  REG1          = 5'h1F,
  parameter logic [15:0] DATA1         = 16'h0000,
  parameter logic [4:0]  REG2          = 5'h00,
  parameter logic [15:0] DATA2         = 16'h0000,
  parameter logic [4:0]  REG3          = 5'h00,
  parameter logic [15:0] DATA3         = 16'h0000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic phy_resetn,
  output logic mdio_scl,
  output logic mdio_sda,
  output logic phy_init_done,
  output logic busy
);

  typedef enum logic [2:0] {RESET_HOLD, SETTLE, LOAD, SHIFT, GAP, DONE} state_t;

  localparam logic [31:0] RESET_T  = 32'(RESET_CYCLES);
  localparam logic [31:0] SETTLE_T = 32'(SETTLE_CYCLES);
  localparam logic [31:0] HALF_T   = 32'(HALF_PERIOD);
  localparam logic [31:0] GAP_T    = 32'(4 * HALF_PERIOD);
  localparam logic [2:0]  NUM_W    = 3'(NUM_WRITES);

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [2:0]  idx, idx_nxt, idx_inc;
  logic [6:0]  half_cnt, half_cnt_nxt;
  logic [63:0] shreg, shreg_nxt;
  logic        resetn_nxt, scl_nxt, sda_nxt, done_nxt;
  logic        timer_expired;
  logic [4:0]  reg_sel;
  logic [15:0] data_sel;
  logic [63:0] frame;

  always_comb begin
    reg_sel  = REG3;
    data_sel = DATA3;
    case (idx)
      3'd0: begin reg_sel = REG0; data_sel = DATA0; end
      3'd1: begin reg_sel = REG1; data_sel = DATA1; end
      3'd2: begin reg_sel = REG2; data_sel = DATA2; end
      default: ;
    endcase
  end

  assign frame         = {32'hFFFF_FFFF, 4'b0101, PHY_ADDR, reg_sel, 2'b10, data_sel};
  assign timer_expired = (timer <= 32'd1);
  assign idx_inc       = idx + 3'd1;

  // shreg holds the bits still to be sent, next bit in [63]; mdio_scl doubles as the phase flag
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    idx_nxt      = idx;
    half_cnt_nxt = half_cnt;
    shreg_nxt    = shreg;
    resetn_nxt   = phy_resetn;
    scl_nxt      = mdio_scl;
    sda_nxt      = mdio_sda;
    done_nxt     = phy_init_done;
    case (state)
      RESET_HOLD: begin
        if (timer_expired) begin
          state_nxt  = SETTLE;
          timer_nxt  = SETTLE_T;
          resetn_nxt = 1'b1;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      SETTLE: begin
        if (timer_expired) begin
          if (NUM_W == 3'd0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      LOAD: begin
        state_nxt    = SHIFT;
        timer_nxt    = HALF_T;
        half_cnt_nxt = 7'd127;
        shreg_nxt    = {frame[62:0], 1'b0};
        scl_nxt      = 1'b0;
        sda_nxt      = frame[63];
      end
      SHIFT: begin
        if (!timer_expired) begin
          timer_nxt = timer - 32'd1;
        end else if (half_cnt == 7'd0) begin
          state_nxt = GAP;
          timer_nxt = GAP_T;
          scl_nxt   = 1'b0;
          sda_nxt   = 1'b1;
        end else begin
          half_cnt_nxt = half_cnt - 7'd1;
          timer_nxt    = HALF_T;
          if (!mdio_scl) begin
            scl_nxt = 1'b1;
          end else begin
            scl_nxt   = 1'b0;
            sda_nxt   = shreg[63];
            shreg_nxt = {shreg[62:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (timer_expired) begin
          idx_nxt = idx_inc;
          if (idx_inc < NUM_W) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      DONE: begin
        if (restart) begin
          state_nxt  = RESET_HOLD;
          timer_nxt  = RESET_T;
          idx_nxt    = 3'd0;
          resetn_nxt = 1'b0;
          done_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = RESET_HOLD;
        timer_nxt = RESET_T;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RESET_HOLD;
      timer         <= RESET_T;
      idx           <= 3'd0;
      half_cnt      <= 7'd0;
      shreg         <= '0;
      phy_resetn    <= 1'b0;
      mdio_scl      <= 1'b0;
      mdio_sda      <= 1'b1;
      phy_init_done <= 1'b0;
      busy          <= 1'b1;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      idx           <= idx_nxt;
      half_cnt      <= half_cnt_nxt;
      shreg         <= shreg_nxt;
      phy_resetn    <= resetn_nxt;
      mdio_scl      <= scl_nxt;
      mdio_sda      <= sda_nxt;
      phy_init_done <= done_nxt;
      busy          <= ~done_nxt;
    end
  end

endmodule

// File: tb/tb_mdio_phy_init.sv
// Bench for mdio_phy_init: fixed waveform vectors, frame capture sequences and a
// randomized restart/reset run checked against a cycle-indexed waveform model.
module tb_mdio_phy_init;
  localparam int HP = 2;
  localparam int RC = 10;
  localparam int SC = 20;
  localparam int FL = 1 + 128 * HP + 4 * HP;   // LOAD + SHIFT + GAP
  localparam int DONE2 = RC + SC + 2 * FL;     // 560
  localparam int DONE0 = RC + SC;              // 30

  logic clock = 1'b0;
  logic reset, restart;
  logic phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy;
  logic z_resetn, z_scl, z_sda, z_done, z_busy;

  int n_pass = 0;
  int n_total = 0;

  mdio_phy_init #(.HALF_PERIOD(HP), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)) dut (
    .clock(clock), .reset(reset), .restart(restart), .phy_resetn(phy_resetn),
    .mdio_scl(mdio_scl), .mdio_sda(mdio_sda), .phy_init_done(phy_init_done), .busy(busy));

  mdio_phy_init #(.HALF_PERIOD(HP), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .NUM_WRITES(0)) dut_nw0 (
    .clock(clock), .reset(reset), .restart(restart), .phy_resetn(z_resetn),
    .mdio_scl(z_scl), .mdio_sda(z_sda), .phy_init_done(z_done), .busy(z_busy));

  always #5 clock = ~clock;

  typedef struct {
    int         t;
    logic [4:0] exp_main;  // {phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy}
    logic       exp_z_done;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] outs_main();
    return {phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy};
  endfunction

  function automatic logic [4:0] outs_z();
    return {z_resetn, z_scl, z_sda, z_done, z_busy};
  endfunction

  function automatic logic [63:0] frame_of(int f);
    logic [4:0]  r;
    logic [15:0] d;
    r = (f == 0) ? 5'h00 : 5'h1F;
    d = (f == 0) ? 16'h1140 : 16'h0000;
    return {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h00, r, 2'b10, d};
  endfunction

  // expected outputs t edges after reset release / accepted restart
  function automatic logic [4:0] model(int t, int nw);
    int r, f, s, b;
    logic hi;
    logic [63:0] fr;
    if (t < RC) return 5'b00101;
    if (t < RC + SC) return 5'b10101;
    if (t >= RC + SC + nw * FL) return 5'b10110;
    r = (t - RC - SC) % FL;
    f = (t - RC - SC) / FL;
    if (r == 0 || r > 128 * HP) return 5'b10101;
    s  = r - 1;
    b  = s / (2 * HP);
    hi = (s % (2 * HP)) >= HP;
    fr = frame_of(f);
    return {1'b1, hi, fr[63 - b], 1'b0, 1'b1};
  endfunction

  task automatic capture(input int restart_at, output logic [63:0] f0, output logic [63:0] f1,
                         output int nbits, output int done_t, output int z_done_t, output int z_scl_hi);
    logic [127:0] bits;
    logic prev;
    int t;
    bits = '0; prev = mdio_scl; t = 0;
    nbits = 0; done_t = -1; z_done_t = -1; z_scl_hi = 0;
    while (done_t < 0 && t < 3000) begin
      restart = (t == restart_at);
      tick();
      restart = 1'b0;
      t++;
      if (mdio_scl && !prev) begin
        bits = {bits[126:0], mdio_sda};
        nbits++;
      end
      prev = mdio_scl;
      if (z_scl) z_scl_hi++;
      if (z_done && z_done_t < 0) z_done_t = t;
      if (phy_init_done) done_t = t;
    end
    f0 = bits[127:64];
    f1 = bits[63:0];
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      tick();
      if (mdio_scl || !mdio_sda || !phy_init_done) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    logic [63:0] f0, f1;
    int nbits, done_t, z_done_t, z_scl_hi, cur, t0, t1, rst_left;
    bit rs;

    vecs[0]  = '{0,   5'b00101, 1'b0};
    vecs[1]  = '{9,   5'b00101, 1'b0};
    vecs[2]  = '{10,  5'b10101, 1'b0};
    vecs[3]  = '{29,  5'b10101, 1'b0};
    vecs[4]  = '{30,  5'b10101, 1'b1};
    vecs[5]  = '{31,  5'b10101, 1'b1};
    vecs[6]  = '{33,  5'b11101, 1'b1};
    vecs[7]  = '{159, 5'b10001, 1'b1};
    vecs[8]  = '{161, 5'b11001, 1'b1};
    vecs[9]  = '{163, 5'b10101, 1'b1};
    vecs[10] = '{195, 5'b10001, 1'b1};
    vecs[11] = '{286, 5'b11001, 1'b1};
    vecs[12] = '{287, 5'b10101, 1'b1};
    vecs[13] = '{460, 5'b10101, 1'b1};
    vecs[14] = '{559, 5'b10101, 1'b1};
    vecs[15] = '{560, 5'b10110, 1'b1};

    reset = 1'b1;
    restart = 1'b0;
    repeat (3) tick();
    check("reset_outs", {outs_main(), outs_z()}, {5'b00101, 5'b00101});

    reset = 1'b0;
    cur = 0;
    for (int i = 0; i < 16; i++) begin
      while (cur < vecs[i].t) begin
        tick();
        cur++;
      end
      check($sformatf("vec[%0d] t=%0d", i, vecs[i].t), {outs_main(), z_done},
            {vecs[i].exp_main, vecs[i].exp_z_done});
    end
    check_quiet("post_done_idle", 40);

    // restart from DONE, with a second restart pulse landing mid-frame 0
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_clear", {phy_init_done, phy_resetn, busy}, 3'b001);
    capture(150, f0, f1, nbits, done_t, z_done_t, z_scl_hi);
    check("restart_frame0", f0, 64'hFFFF_FFFF_5002_1140);
    check("restart_frame1", f1, 64'hFFFF_FFFF_507E_0000);
    check("restart_nbits", nbits, 128);
    check("restart_done_t", done_t, DONE2);
    check("nw0_done_t", z_done_t, DONE0);
    check("nw0_scl_quiet", z_scl_hi, 0);
    check_quiet("restart_post_done", 100);

    // reset asserted in frame 1, bit 20
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (377) tick();
    check("pre_abort", outs_main(), model(377, 2));
    reset = 1'b1;
    #1;
    check("abort_async", {outs_main(), outs_z()}, {5'b00101, 5'b00101});
    repeat (3) tick();
    check("abort_hold", outs_main(), 5'b00101);
    reset = 1'b0;
    capture(-1, f0, f1, nbits, done_t, z_done_t, z_scl_hi);
    check("rerun_frame0", f0, 64'hFFFF_FFFF_5002_1140);
    check("rerun_frame1", f1, 64'hFFFF_FFFF_507E_0000);
    check("rerun_nbits", nbits, 128);
    check("rerun_done_t", done_t, DONE2);
    check("rerun_nw0_done_t", z_done_t, DONE0);

    // randomized restart / reset traffic against the waveform model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    t0 = 0; t1 = 0; rst_left = 0;
    for (int c = 0; c < 8000; c++) begin
      rs = 1'b0;
      if (reset) begin
        if (rst_left == 0) begin
          reset = 1'b0;
          t0 = 0;
          t1 = 0;
        end else begin
          rst_left--;
        end
      end else if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        rst_left = $urandom_range(0, 2);
        #1;
        check("rand_async_reset", {outs_main(), outs_z()}, {5'b00101, 5'b00101});
      end else begin
        rs = ($urandom_range(0, 39) == 0);
        restart = rs;
      end
      tick();
      restart = 1'b0;
      if (reset) begin
        t0 = 0;
        t1 = 0;
      end else begin
        t0 = (rs && t0 >= DONE2) ? 0 : t0 + 1;
        t1 = (rs && t1 >= DONE0) ? 0 : t1 + 1;
      end
      check($sformatf("rand c=%0d t0=%0d t1=%0d", c, t0, t1), {outs_main(), outs_z()},
            {model(t0, 2), model(t1, 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
